muldiv_sequencer: RTL and testbench

Iterative multiply/divide engine and sequencer for the HI/LO register pair, used by MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It sits beside the ALU in the execute stage and is driven by the decoder's `mult`, `div` and `isUnsigned` outputs. It owns HI/LO and runs a 32-iteration shift-add multiply or restoring divide. It stalls the pipeline whenever an instruction touches HI/LO or starts a new operation while it is busy.

---
 rtl/muldiv_sequencer_if.sv | 40 ++++
 rtl/muldiv_sequencer.sv | 171 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer_if
// Purpose  : Execute-stage bus between the pipeline and the HI/LO engine.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mult;
  logic             div;
  logic             isUnsigned;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] wData;
  logic             readHi;
  logic             readLo;
  logic             cancel;
  logic [WIDTH-1:0] rData;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mult, div, isUnsigned, opA, opB,
    output hiWrite, loWrite, wData, readHi, readLo, cancel,
    input  rData, busy, stall, hi, lo
  );

  modport slave (
    input  start, mult, div, isUnsigned, opA, opB,
    input  hiWrite, loWrite, wData, readHi, readLo, cancel,
    output rData, busy, stall, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative 32-step shift-add multiply / restoring divide owning HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstN,
  muldiv_sequencer_if.slave  bus
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_isDiv;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_rawA;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_busy;
  logic               w_accept;
  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.cancel && (bus.mult ^ bus.div);

  assign w_signA = !bus.isUnsigned && bus.opA[WIDTH-1];
  assign w_signB = !bus.isUnsigned && bus.opB[WIDTH-1];
  assign w_absA  = w_signA ? -bus.opA : bus.opA;
  assign w_absB  = w_signB ? -bus.opB : bus.opB;

  // Product register: upper half accumulates, lower half holds the unconsumed multiplier bits.
  assign w_mulSum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_mulNext = {w_mulSum, r_prod[WIDTH-1:1]};

  // Remainder stays below the divisor, so the 33-bit difference never overflows its sign bit.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign w_ge    = !w_diff[WIDTH];

  assign w_prodFix = r_negRes ? -r_prod : r_prod;
  assign w_quoFix  = r_negRes ? -r_quo  : r_quo;
  assign w_remFix  = r_negRem ? -r_rem  : r_rem;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (bus.cancel)           w_next = S_IDLE;
        else if (r_cnt == C_LAST) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_rawA    <= '0;
      r_mcand   <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_prod    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_isDiv   <= bus.div;
            r_negRes  <= w_signA ^ w_signB;
            r_negRem  <= w_signA;
            r_divZero <= bus.div && (bus.opB == '0);
            r_rawA    <= bus.opA;
            r_mcand   <= w_absA;
            r_divisor <= w_absB;
            r_prod    <= {{WIDTH{1'b0}}, w_absB};
            r_quo     <= w_absA;
            r_rem     <= '0;
          end else if (!bus.cancel) begin
            if (bus.hiWrite) r_hi <= bus.wData;
            if (bus.loWrite) r_lo <= bus.wData;
          end
        end
        S_RUN: begin
          if (bus.cancel) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_isDiv) begin
              r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], w_ge};
            end else begin
              r_prod <= w_mulNext;
            end
          end
        end
        S_FIX: begin
          if (!bus.cancel) begin
            if (!r_isDiv) begin
              r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
              r_lo <= w_prodFix[WIDTH-1:0];
            end else if (r_divZero) begin
              r_hi <= r_rawA;
              r_lo <= '1;
            end else begin
              r_hi <= w_remFix;
              r_lo <= w_quoFix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = w_busy;
  assign bus.stall = w_busy & (bus.start | bus.readHi | bus.readLo | bus.hiWrite | bus.loWrite);
  assign bus.rData = bus.readHi ? r_hi : r_lo;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Directed plus randomized checks of muldiv_sequencer against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rstN;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  // Returns {HI, LO} computed with native 64-bit / signed arithmetic.
  function automatic logic [63:0] model(input bit isdiv, input bit uns,
                                        input logic [31:0] a, input logic [31:0] b);
    longint     sp;
    logic [63:0] up;
    logic [31:0] q;
    logic [31:0] r;
    if (!isdiv) begin
      if (uns) begin
        up = {32'd0, a} * {32'd0, b};
      end else begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
      end
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (uns) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit isdiv, input bit uns, input logic [31:0] a, input logic [31:0] b);
    bus.start      = 1'b1;
    bus.mult       = !isdiv;
    bus.div        = isdiv;
    bus.isUnsigned = uns;
    bus.opA        = a;
    bus.opB        = b;
    tick();
    bus.start = 1'b0;
    bus.mult  = 1'b0;
    bus.div   = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_check(input string tag, input bit isdiv, input bit uns,
                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          cyc;
    e = model(isdiv, uns, a, b);
    issue(isdiv, uns, a, b);
    check({tag, " busy"}, 64'(bus.busy), 64'd1);
    wait_done(cyc);
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " hi"}, 64'(bus.hi), 64'(e[63:32]));
    check({tag, " lo"}, 64'(bus.lo), 64'(e[31:0]));
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wd;
    bit          isdiv;
    bit          uns;
    bit          bad;
    int          cyc;

    rstN = 1'b0;
    bus.start = 0; bus.mult = 0; bus.div = 0; bus.isUnsigned = 0;
    bus.opA = '0; bus.opB = '0; bus.hiWrite = 0; bus.loWrite = 0;
    bus.wData = '0; bus.readHi = 0; bus.readLo = 0; bus.cancel = 0;
    repeat (3) tick();
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset rData", 64'(bus.rData), 64'd0);
    rstN = 1'b1;
    tick();

    // Directed arithmetic cases, issued back to back.
    run_check("mult neg", 1'b0, 1'b0, 32'hFFFFFFFD, 32'd7);
    check("mult neg const hi", 64'(bus.hi), 64'hFFFFFFFF);
    check("mult neg const lo", 64'(bus.lo), 64'hFFFFFFEB);
    run_check("multu max", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_check("div -7/2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
    check("div -7/2 const lo", 64'(bus.lo), 64'hFFFFFFFD);
    run_check("div ovf", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    check("div ovf const lo", 64'(bus.lo), 64'h80000000);
    run_check("divu by0", 1'b1, 1'b1, 32'd7, 32'd0);
    run_check("div neg by0", 1'b1, 1'b0, 32'hFFFFFF00, 32'd0);
    run_check("mult minint", 1'b0, 1'b0, 32'h80000000, 32'h80000000);

    // Read port priority in IDLE (HI/LO hold the last product).
    e = model(1'b0, 1'b0, 32'h80000000, 32'h80000000);
    bus.readHi = 1'b1; bus.readLo = 1'b1; #1;
    check("read both", 64'(bus.rData), 64'(e[63:32]));
    bus.readHi = 1'b0; #1;
    check("read lo", 64'(bus.rData), 64'(e[31:0]));
    bus.readLo = 1'b0;

    // A write coinciding with an accepted start is dropped.
    bus.hiWrite = 1'b1; bus.wData = 32'hA5A5A5A5;
    issue(1'b0, 1'b1, 32'd3, 32'd5);
    bus.hiWrite = 1'b0;
    check("write dropped on start", 64'(bus.hi), 64'(e[63:32]));
    wait_done(cyc);

    // Malformed starts are ignored.
    bus.start = 1'b1; bus.mult = 1'b1; bus.div = 1'b1;
    tick();
    check("start both ignored", 64'(bus.busy), 64'd0);
    bus.mult = 1'b0; bus.div = 1'b0;
    tick();
    check("start neither ignored", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      isdiv = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      a = (i % 9 == 4) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_check($sformatf("rand%0d", i), isdiv, uns, a, b);
    end

    // MFHI raised mid-operation must stall until the result is written.
    a = 32'hDEAD0001; b = 32'hFFFF1234;
    e = model(1'b0, 1'b0, a, b);
    issue(1'b0, 1'b0, a, b);
    repeat (4) tick();
    bus.readHi = 1'b1; #1;
    check("mfhi stall", 64'(bus.stall), 64'd1);
    bad = 1'b0; cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (bus.busy === 1'b1 && bus.stall !== 1'b1) bad = 1'b1;
    end
    check("mfhi stall held", 64'(bad), 64'd0);
    check("mfhi released", 64'(bus.stall), 64'd0);
    check("mfhi rData", 64'(bus.rData), 64'(e[63:32]));
    bus.readHi = 1'b0;

    // MTLO raised mid-operation lands after the result.
    a = 32'd1000; b = 32'hFFFFFFF3;
    e = model(1'b1, 1'b0, a, b);
    wd = $urandom;
    issue(1'b1, 1'b0, a, b);
    repeat (3) tick();
    bus.loWrite = 1'b1; bus.wData = wd; #1;
    check("mtlo stall", 64'(bus.stall), 64'd1);
    wait_done(cyc);
    check("mtlo result first", 64'(bus.lo), 64'(e[31:0]));
    tick();
    bus.loWrite = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'(wd));
    check("mtlo hi", 64'(bus.hi), 64'(e[63:32]));

    // Cancel in RUN leaves HI/LO untouched.
    bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.wData = 32'h12345678;
    tick();
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    check("mt hi", 64'(bus.hi), 64'h12345678);
    check("mt lo", 64'(bus.lo), 64'h12345678);
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    repeat (10) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel run busy", 64'(bus.busy), 64'd0);
    check("cancel run hi", 64'(bus.hi), 64'h12345678);
    check("cancel run lo", 64'(bus.lo), 64'h12345678);

    // Cancel in IDLE blocks both start and MTHI.
    bus.cancel = 1'b1; bus.start = 1'b1; bus.mult = 1'b1;
    bus.hiWrite = 1'b1; bus.wData = 32'hDEADBEEF;
    tick();
    bus.cancel = 1'b0; bus.start = 1'b0; bus.mult = 1'b0; bus.hiWrite = 1'b0;
    check("cancel idle busy", 64'(bus.busy), 64'd0);
    check("cancel idle hi", 64'(bus.hi), 64'h12345678);

    // Cancel in FIX suppresses the writeback.
    issue(1'b0, 1'b1, 32'd9, 32'd9);
    repeat (32) tick();
    check("fix busy", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel fix busy", 64'(bus.busy), 64'd0);
    check("cancel fix hi", 64'(bus.hi), 64'h12345678);
    check("cancel fix lo", 64'(bus.lo), 64'h12345678);

    // Asynchronous reset mid-RUN.
    issue(1'b0, 1'b0, 32'd11, 32'd13);
    repeat (5) tick();
    rstN = 1'b0;
    #1;
    check("async rst hi", 64'(bus.hi), 64'd0);
    check("async rst lo", 64'(bus.lo), 64'd0);
    check("async rst busy", 64'(bus.busy), 64'd0);
    tick();
    rstN = 1'b1;
    tick();
    run_check("post reset", 1'b1, 1'b1, 32'd12345, 32'd77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
